// File: rtl/serv_lsu_defs.sv
// serv_lsu_defs -- shared definitions for the serial load/store sequencer.
//   state_e : sequencer phases (IDLE, INIT, CHECK, BUS, RUN)
//   CNT_W   : width of the in-phase bit counter
//   TO_W    : width of the optional bus-wait counter
package serv_lsu_defs;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned TO_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_BUS   = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

endpackage

// File: rtl/serv_lsu_cnt.sv
// serv_lsu_cnt -- 5-bit phase counter shared by the INIT and RUN phases.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : synchronous clear (priority over i_en)
//   i_en         : count enable; wraps 31 -> 0
//   o_cnt        : current count
//   o_done       : i_en while the count is at its last value
module serv_lsu_cnt
  import serv_lsu_defs::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_done = i_en & (cnt_q == '1);

endmodule

// File: rtl/serv_lsu_seq.sv
// serv_lsu_seq -- phase sequencer for the bit-serial load/store datapath.
// Steps an access through INIT (32 shift cycles), CHECK (misalign), BUS
// (Wishbone cycle) and, for loads, RUN (32 result shift cycles).
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_start, i_store    : access request and direction (sampled in IDLE)
//   i_misalign          : misalign flag, sampled in CHECK
//   i_wb_ack            : data-bus acknowledge
//   o_busy/o_init/o_en  : phase decodes for the datapath
//   o_cnt/o_bytecnt     : bit counter and its byte index
//   o_cnt_done          : last bit of an enabled phase
//   o_wb_cyc/o_wb_we    : registered bus request
//   o_trap/o_done       : one-cycle misalign / completion pulses
//   o_bus_err           : one-cycle bus timeout pulse
// Optional macro SERV_LSU_TIMEOUT_EN builds a bus-wait limit of
// TIMEOUT_CYCLES cycles; otherwise BUS waits forever and o_bus_err is 0.
module serv_lsu_seq
  import serv_lsu_defs::*;
#(
  parameter int unsigned WITH_CSR       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_store,
  input  logic             i_misalign,
  input  logic             i_wb_ack,
  output logic             o_busy,
  output logic             o_init,
  output logic             o_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic [1:0]       o_bytecnt,
  output logic             o_cnt_done,
  output logic             o_wb_cyc,
  output logic             o_wb_we,
  output logic             o_trap,
  output logic             o_done,
  output logic             o_bus_err
);

  state_e state_q, state_d;
  logic   store_q, store_d;
  logic   cyc_q, cyc_d;
  logic   we_q, we_d;
  logic   trap_q, trap_d;
  logic   done_q, done_d;
  logic   cnt_clr;
  logic   cnt_last;

`ifdef SERV_LSU_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_q, wait_d;
  logic            err_q, err_d;
`endif

  assign o_busy = (state_q != ST_IDLE);
  assign o_init = (state_q == ST_INIT);
  assign o_en   = (state_q == ST_INIT) || (state_q == ST_RUN);

  serv_lsu_cnt u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (cnt_clr),
    .i_en   (o_en),
    .o_cnt  (o_cnt),
    .o_done (cnt_last)
  );

  assign o_bytecnt  = o_cnt[CNT_W-1:CNT_W-2];
  assign o_cnt_done = cnt_last;

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    trap_d  = 1'b0;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
`ifdef SERV_LSU_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          store_d = i_store;
          cnt_clr = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        if (cnt_last) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if ((WITH_CSR != 0) && i_misalign) begin
          trap_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cyc_d   = 1'b1;
          we_d    = store_q;
          state_d = ST_BUS;
`ifdef SERV_LSU_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      ST_BUS: begin
        // ack is checked before the wait limit so a same-cycle ack completes
        if (i_wb_ack) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (store_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_clr = 1'b1;
            state_d = ST_RUN;
          end
        end
`ifdef SERV_LSU_TIMEOUT_EN
        else if (wait_q == TO_LIMIT) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
`endif
      end
      ST_RUN: begin
        if (cnt_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      trap_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERV_LSU_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      trap_q  <= trap_d;
      done_q  <= done_d;
`ifdef SERV_LSU_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o_wb_cyc = cyc_q;
  assign o_wb_we  = we_q;
  assign o_trap   = trap_q;
  assign o_done   = done_q;

`ifdef SERV_LSU_TIMEOUT_EN
  assign o_bus_err = err_q;
`else
  // no timeout logic: constant 0, parameter retained for override compatibility
  assign o_bus_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_serv_lsu_seq.sv
// tb_serv_lsu_seq -- self-checking bench for serv_lsu_seq.
// Two instances share stimulus: index 0 has WITH_CSR=1, index 1 WITH_CSR=0.
module tb_serv_lsu_seq;

  localparam int TB_TO = 4;
  localparam int N     = 800;
`ifdef SERV_LSU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, store, mis;
  logic       ack   [2];
  logic       busy  [2];
  logic       init  [2];
  logic       en    [2];
  logic [4:0] cnt   [2];
  logic [1:0] bcnt  [2];
  logic       cdone [2];
  logic       cyc   [2];
  logic       we    [2];
  logic       trap  [2];
  logic       done  [2];
  logic       berr  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serv_lsu_seq #(.WITH_CSR(1), .TIMEOUT_CYCLES(TB_TO)) u_csr (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_store(store),
    .i_misalign(mis), .i_wb_ack(ack[0]),
    .o_busy(busy[0]), .o_init(init[0]), .o_en(en[0]), .o_cnt(cnt[0]),
    .o_bytecnt(bcnt[0]), .o_cnt_done(cdone[0]), .o_wb_cyc(cyc[0]),
    .o_wb_we(we[0]), .o_trap(trap[0]), .o_done(done[0]), .o_bus_err(berr[0])
  );

  serv_lsu_seq #(.WITH_CSR(0), .TIMEOUT_CYCLES(TB_TO)) u_nocsr (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_store(store),
    .i_misalign(mis), .i_wb_ack(ack[1]),
    .o_busy(busy[1]), .o_init(init[1]), .o_en(en[1]), .o_cnt(cnt[1]),
    .o_bytecnt(bcnt[1]), .o_cnt_done(cdone[1]), .o_wb_cyc(cyc[1]),
    .o_wb_we(we[1]), .o_trap(trap[1]), .o_done(done[1]), .o_bus_err(berr[1])
  );

  // Expected output word: {busy,init,en,cnt,bytecnt,cnt_done,cyc,we&cyc,trap,done,bus_err}
  function automatic logic [15:0] pk(bit b, bit i, bit e, int c, bit cy, bit w,
                                     bit t, bit d, bit x);
    logic [4:0] c5;
    logic [1:0] bc;
    c5 = 5'(c);
    bc = 2'(c / 8);
    return {b, i, e, c5, bc, e && (c == 31), cy, w && cy, t, d, x};
  endfunction

  function automatic logic [15:0] act(int d);
    return {busy[d], init[d], en[d], cnt[d], bcnt[d], cdone[d], cyc[d],
            we[d] & cyc[d], trap[d], done[d], berr[d]};
  endfunction

  task automatic chk(input string name, input int d, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, d, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; store = 1'b0; mis = 1'b0; ack[0] = 1'b0; ack[1] = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // ---------------- directed single transaction ----------------
  int r_done[2], r_ndone[2], r_trap[2], r_err[2], r_cyc[2];
  bit r_weok[2];

  // Offsets are counted from the cycle in which i_start is presented (k=0).
  // Each DUT acks its own bus cycle after wn cycles of waiting.
  task automatic run_txn(input bit st, input bit m, input int wn);
    for (int d = 0; d < 2; d++) begin
      r_done[d] = -1; r_ndone[d] = 0; r_trap[d] = -1; r_err[d] = -1;
      r_cyc[d] = 0; r_weok[d] = 1'b1;
    end
    store = st;
    mis   = m;
    for (int k = 0; k < 90; k++) begin
      start = (k == 0);
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          if (r_done[d] < 0) r_done[d] = k;
          r_ndone[d]++;
        end
        if (trap[d] && r_trap[d] < 0) r_trap[d] = k;
        if (berr[d] && r_err[d] < 0) r_err[d] = k;
        ack[d] = cyc[d] && (r_cyc[d] == wn);
        if (cyc[d]) begin
          r_cyc[d]++;
          if (we[d] !== st) r_weok[d] = 1'b0;
        end
      end
      tick();
    end
    start = 1'b0; mis = 1'b0; ack[0] = 1'b0; ack[1] = 1'b0;
  endtask

  typedef struct {
    bit st; bit m; int wn;
    int done0; int trap0; int cyc0;
    int done1; int trap1; int cyc1;
  } vec_t;

  vec_t tbl[6];

  // ---------------- randomized run with timeline reference ----------------
  logic        r_start[N], r_store[N], r_mis[N], r_ack[N];
  logic [15:0] expv[2][N];

  task automatic put(input int d, input int c, input logic [15:0] v);
    if (c < N) expv[d][c] = v;
  endtask

  // Lays each accepted access out on a cycle timeline: 32 INIT cycles,
  // one CHECK cycle, bus cycles until ack (or the wait limit), then either
  // a done pulse (store) or 32 RUN cycles followed by the done pulse.
  task automatic build_model(input int d, input bit csr);
    int c, s, ch, b, w, outcome;
    for (int i = 0; i < N; i++) expv[d][i] = '0;
    c = 0;
    while (c < N) begin
      if (!r_start[c]) begin
        c++;
        continue;
      end
      s = c;
      for (int i = 0; i < 32; i++) put(d, s + 1 + i, pk(1, 1, 1, i, 0, 0, 0, 0, 0));
      ch = s + 33;
      put(d, ch, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      if (ch >= N) break;
      if (csr && r_mis[ch]) begin
        put(d, ch + 1, pk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        c = ch + 1;
        continue;
      end
      b = ch + 1; w = 0; outcome = 2;
      while (b < N) begin
        put(d, b, pk(1, 0, 0, 0, 1, r_store[s], 0, 0, 0));
        if (r_ack[b]) begin outcome = 0; break; end
        if (TO_EN && w == TB_TO - 1) begin outcome = 1; break; end
        b++; w++;
      end
      if (outcome == 2) break;
      if (outcome == 1) begin
        put(d, b + 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        c = b + 1;
      end else if (r_store[s]) begin
        put(d, b + 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        c = b + 1;
      end else begin
        for (int i = 0; i < 32; i++) put(d, b + 1 + i, pk(1, 0, 1, i, 0, 0, 0, 0, 0));
        put(d, b + 33, pk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        c = b + 33;
      end
    end
  endtask

  int hd[2][3];
  int hn[2];
  int nprint;
  int wcnt;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 3, 70, -1, 4, 70, -1, 4};
    tbl[1] = '{1'b1, 1'b0, 0, 35, -1, 1, 35, -1, 1};
    tbl[2] = '{1'b0, 1'b0, 0, 67, -1, 1, 67, -1, 1};
    tbl[3] = '{1'b1, 1'b1, 0, -1, 34, 0, 35, -1, 1};
    tbl[4] = '{1'b0, 1'b1, 2, -1, 34, 0, 69, -1, 3};
    tbl[5] = '{1'b1, 1'b0, 2, 37, -1, 3, 37, -1, 3};

    rst = 1'b0;
    tick();
    do_reset();
    #1;
    for (int d = 0; d < 2; d++) chk("reset_state", d, int'(act(d)), 0);

    // table-driven single accesses
    for (int t = 0; t < 6; t++) begin
      run_txn(tbl[t].st, tbl[t].m, tbl[t].wn);
      chk("done_at",  0, r_done[0], tbl[t].done0);
      chk("trap_at",  0, r_trap[0], tbl[t].trap0);
      chk("cyc_len",  0, r_cyc[0],  tbl[t].cyc0);
      chk("done_at",  1, r_done[1], tbl[t].done1);
      chk("trap_at",  1, r_trap[1], tbl[t].trap1);
      chk("cyc_len",  1, r_cyc[1],  tbl[t].cyc1);
      for (int d = 0; d < 2; d++) begin
        chk("done_cnt", d, r_ndone[d], ((d == 0 ? tbl[t].done0 : tbl[t].done1) >= 0) ? 1 : 0);
        chk("we_match", d, int'(r_weok[d]), 1);
        chk("no_buserr", d, r_err[d], -1);
      end
    end

    // i_start held with ack held: back-to-back stores every 35 cycles
    tick();
    do_reset();
    store = 1'b1; ack[0] = 1'b1; ack[1] = 1'b1; start = 1'b1;
    hn[0] = 0; hn[1] = 0;
    for (int k = 0; k < 110; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          if (hn[d] < 3) hd[d][hn[d]] = k;
          hn[d]++;
        end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      chk("b2b_count", d, hn[d], 3);
      for (int i = 0; i < 3; i++) chk("b2b_done_at", d, (hn[d] > i) ? hd[d][i] : -1, 35 * (i + 1));
    end

    // asynchronous reset in the middle of a bus cycle
    tick();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    wcnt = 0;
    while (!cyc[0] && wcnt < 60) begin
      tick();
      wcnt++;
    end
    chk("cyc_reached", 0, int'(cyc[0]), 1);
    tick();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("async_reset_out", d, int'({act(d), we[d]}), 0);
    #1 rst = 1'b0;
    run_txn(1'b1, 1'b0, 0);
    for (int d = 0; d < 2; d++) begin
      chk("post_reset_done_at", d, r_done[d], 35);
      chk("post_reset_done_cnt", d, r_ndone[d], 1);
    end

`ifdef SERV_LSU_TIMEOUT_EN
    // no ack at all: error pulse after TB_TO bus cycles
    run_txn(1'b0, 1'b0, 99);
    for (int d = 0; d < 2; d++) begin
      chk("timeout_err_at", d, r_err[d], 33 + TB_TO + 1);
      chk("timeout_cyc_len", d, r_cyc[d], TB_TO);
      chk("timeout_no_done", d, r_ndone[d], 0);
    end
    // ack on the last allowed cycle completes normally
    run_txn(1'b0, 1'b0, TB_TO - 1);
    for (int d = 0; d < 2; d++) begin
      chk("limit_ack_done_at", d, r_done[d], 67 + TB_TO - 1);
      chk("limit_ack_no_err", d, r_err[d], -1);
    end
`endif

    // randomized stimulus against the timeline reference
    for (int c = 0; c < N; c++) begin
      r_start[c] = ($urandom_range(0, 19) == 0);
      r_store[c] = 1'($urandom_range(0, 1));
      r_mis[c]   = ($urandom_range(0, 3) == 0);
      r_ack[c]   = ($urandom_range(0, 2) == 0);
    end
    build_model(0, 1'b1);
    build_model(1, 1'b0);
    tick();
    do_reset();
    nprint = 0;
    for (int c = 0; c < N; c++) begin
      start = r_start[c]; store = r_store[c]; mis = r_mis[c];
      ack[0] = r_ack[c]; ack[1] = r_ack[c];
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (act(d) !== expv[d][c]) begin
          n_fail++;
          if (nprint < 12)
            $display("FAIL random_cycle%0d dut%0d: got %h expected %h", c, d, act(d), expv[d][c]);
          nprint++;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
